bcd_to_bin_n: RTL and testbench

BCD_TO_BIN_N -- requirements
Module: bcd_to_bin_n

---
 rtl/bcd_to_bin_n.sv | 137 +++++++++++++
 tb/tb_bcd_to_bin_n.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_n.sv
// bcd_to_bin_n: multi-digit packed BCD to binary converter (reverse double-dabble).
//
// One conversion takes 2*BW+1 cycles from the accepting edge to the done pulse.
// Each of the BW iterations is one SHIFT cycle and one CORR cycle.
//
// Parameters:
//   NDIG  number of BCD digits (1..8)
//   BW    binary result width, 2^BW >= 10^NDIG
//
// Ports:
//   clk      clock, rising edge
//   rst      asynchronous active-high reset
//   start    conversion request, sampled only in IDLE
//   bcd_in   packed BCD operand, digit 0 in bits [3:0]
//   bin_out  registered binary result, held until the next completion
//   busy     high whenever the FSM is not in IDLE
//   done     single-cycle completion pulse
//   err      invalid-digit flag (constant 0 unless BCD_DIGIT_CHECK_EN)
//
// Optional feature (macro BCD_DIGIT_CHECK_EN): a start whose operand holds a
// digit above 9 skips the conversion, completes one cycle later with err=1 and
// bin_out=0.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start; operand loaded on the accepting edge
// SHIFT | shift {bcd_reg, bin_reg} right one bit, decrement iteration count
// CORR  | subtract 3 from every BCD digit >= 8; finish when count hits 0
// DONE  | publish bin_reg to bin_out and pulse done on the way back to IDLE

module bcd_to_bin_n #(
  parameter int NDIG = 3,
  parameter int BW   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic [BW-1:0]     bin_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CW = $clog2(BW + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CORR  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [4*NDIG-1:0] bcd_reg;
  logic [4*NDIG-1:0] bcd_corr;
  logic [BW-1:0]     bin_reg;
  logic [CW-1:0]     cnt;

  // A digit is >= 8 exactly when its top bit is set.
  always_comb begin
    bcd_corr = bcd_reg;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_reg[4*i+3]) begin
        bcd_corr[4*i +: 4] = bcd_reg[4*i +: 4] - 4'd3;
      end
    end
  end

`ifdef BCD_DIGIT_CHECK_EN
  logic bad_digit;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (bcd_in[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bcd_reg <= '0;
      bin_reg <= '0;
      cnt     <= '0;
      bin_out <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      err     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd_reg <= bcd_in;
            bin_reg <= '0;
            cnt     <= CW'(BW);
            busy    <= 1'b1;
            state   <= SHIFT;
`ifdef BCD_DIGIT_CHECK_EN
            // bin_reg is already cleared, so an aborted conversion reports 0.
            err <= bad_digit;
            if (bad_digit) begin
              state <= DONE;
            end
`endif
          end
        end
        SHIFT: begin
          bin_reg <= {bcd_reg[0], bin_reg[BW-1:1]};
          bcd_reg <= bcd_reg >> 1;
          cnt     <= cnt - CW'(1);
          state   <= CORR;
        end
        CORR: begin
          bcd_reg <= bcd_corr;
          state   <= (cnt == '0) ? DONE : SHIFT;
        end
        DONE: begin
          bin_out <= bin_reg;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin_n.sv
module tb_bcd_to_bin_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [11:0] bcd_in = '0;
  logic [9:0]  bin_out;
  logic        busy, done, err;

  logic        start_b = 1'b0;
  logic [15:0] bcd_b = '0;
  logic [13:0] bin_b;
  logic        busy_b, done_b, err_b;

  int checks = 0;
  int errors = 0;

`ifdef BCD_DIGIT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  always #5 clk = ~clk;

  bcd_to_bin_n #(.NDIG(3), .BW(10)) dut (
    .clk(clk), .rst(rst), .start(start), .bcd_in(bcd_in),
    .bin_out(bin_out), .busy(busy), .done(done), .err(err)
  );

  bcd_to_bin_n #(.NDIG(4), .BW(14)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .bcd_in(bcd_b),
    .bin_out(bin_b), .busy(busy_b), .done(done_b), .err(err_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dec_val(input logic [11:0] b);
    int v = 0;
    int w = 1;
    for (int i = 0; i < 3; i++) begin
      v += int'(b[4*i +: 4]) * w;
      w *= 10;
    end
    return v;
  endfunction

  function automatic bit all_valid(input logic [11:0] b);
    for (int i = 0; i < 3; i++) begin
      if (b[4*i +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Transaction-level model: a request accepted while idle completes a fixed
  // number of edges later with the decimal value of the sampled operand.
  bit m_busy = 0, m_done = 0, m_err = 0, m_known = 1;
  int m_bin = 0, m_pend = 0, m_remain = 0;
  bit m_pend_known = 1;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_busy = 0; m_done = 0; m_err = 0; m_bin = 0; m_known = 1; m_remain = 0;
      end else begin
        m_done = 0;
        if (m_busy) begin
          m_remain--;
          if (m_remain == 0) begin
            m_busy  = 0;
            m_done  = 1;
            m_bin   = m_pend;
            m_known = m_pend_known;
          end
        end else if (start) begin
          m_busy = 1;
          if (CHK && !all_valid(bcd_in)) begin
            m_err = 1; m_pend = 0; m_pend_known = 1; m_remain = 1;
          end else begin
            m_err = 0;
            m_pend = dec_val(bcd_in);
            m_pend_known = all_valid(bcd_in);
            m_remain = 21;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("cmp_done", 32'(done), 32'(m_done));
      check("cmp_busy", 32'(busy), 32'(m_busy));
      check("cmp_err", 32'(err), 32'(m_err));
      if (m_known) check("cmp_bin", 32'(bin_out), 32'(m_bin));
    end
  end

  task automatic conv(input logic [11:0] v, input int exp_lat, input int exp_bin,
                      input bit chk_bin, input bit exp_err, input string tag);
    int lat = 0;
    @(posedge clk); #2;
    start = 1'b1; bcd_in = v;
    @(posedge clk); #2;
    start = 1'b0; bcd_in = ~v;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    if (chk_bin) check({tag, "_bin"}, 32'(bin_out), 32'(exp_bin));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
  endtask

  initial begin
    int lat;
    int ndone;

    check("model_999", 32'(dec_val(12'h999)), 32'd999);
    check("model_255", 32'(dec_val(12'h255)), 32'd255);
    check("model_valid_1A3", 32'(all_valid(12'h1A3)), 32'd0);

    #3;
    check("rst_bin", 32'(bin_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bin_b", 32'(bin_b), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    conv(12'h999, 21, 999, 1'b1, 1'b0, "c999");

    // back-to-back with start held high: 0x000 then 0x255
    @(posedge clk); #2;
    start = 1'b1; bcd_in = 12'h000;
    @(posedge clk);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    check("b2b0_lat", 32'(lat), 32'd21);
    check("b2b0_bin", 32'(bin_out), 32'd0);
    #1 bcd_in = 12'h255;
    @(posedge clk); #2;
    start = 1'b0; bcd_in = 12'h000;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done) begin lat = k; break; end
    end
    check("b2b1_lat", 32'(lat), 32'd21);
    check("b2b1_bin", 32'(bin_out), 32'd255);

    // restart attempt mid-conversion is ignored
    @(posedge clk); #2;
    start = 1'b1; bcd_in = 12'h123;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 start = 1'b1; bcd_in = 12'h456;
    @(posedge clk); #2;
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("restart_ndone", 32'(ndone), 32'd1);
    check("restart_bin", 32'(bin_out), 32'd123);

    // reset mid-conversion
    @(posedge clk); #2;
    start = 1'b1; bcd_in = 12'h777;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_bin", 32'(bin_out), 32'd0);
    @(posedge clk); #2 rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_ndone", 32'(ndone), 32'd0);
    check("abort_bin_after", 32'(bin_out), 32'd0);
    conv(12'h042, 21, 42, 1'b1, 1'b0, "c042");

    // invalid digit
    if (CHK) conv(12'h1A3, 1, 0, 1'b1, 1'b1, "bad1A3");
    else     conv(12'h1A3, 21, 0, 1'b0, 1'b0, "bad1A3");
    conv(12'h010, 21, 10, 1'b1, 1'b0, "c010");

    // four-digit instance
    @(posedge clk); #2;
    start_b = 1'b1; bcd_b = 16'h9999;
    @(posedge clk); #2;
    start_b = 1'b0; bcd_b = 16'h1234;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      if (done_b) begin lat = k; break; end
    end
    check("n4_lat", 32'(lat), 32'd29);
    check("n4_bin", 32'(bin_b), 32'd9999);
    check("n4_err", 32'(err_b), 32'd0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
